// File: rtl/grf_pkg.sv
// Shared general-register-file constants and the dump engine state encoding.
// Used by the GRF, the dump engine and future forwarding logic.
package grf_pkg;

    localparam int NUM_REGS   = 32;
    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SEND  = 2'd2
    } dump_state_e;

endpackage

// File: rtl/grf_dump.sv
// Walks every GPR through a combinational GRF read port and streams index-tagged
// values over valid/ready, snooping the write port so each beat is a true snapshot.
module grf_dump #(
    parameter int NUM_REGS = grf_pkg::NUM_REGS,
    parameter int ADDR_W   = grf_pkg::REG_ADDR_W,
    parameter int DATA_W   = grf_pkg::REG_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_idx,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              done
);

    import grf_pkg::*;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    dump_state_e       state_r;
    dump_state_e       next_state_s;
    logic              busy_r;
    logic              out_valid_r;
    logic [ADDR_W-1:0] out_idx_r;
    logic [DATA_W-1:0] out_data_r;
    logic              out_last_r;
    logic              done_r;

    logic              hs_s;
    logic              cap_en_s;
    logic              finish_s;
    logic [ADDR_W-1:0] cap_idx_s;
    logic [DATA_W-1:0] cap_data_s;

    // Next-state decode; cap_idx_s doubles as the GRF read address.
    always_comb begin
        next_state_s = state_r;
        cap_en_s     = 1'b0;
        finish_s     = 1'b0;
        cap_idx_s    = out_idx_r + ADDR_W'(1);
        hs_s         = out_valid_r && out_ready;
        case (state_r)
            IDLE: begin
                cap_idx_s = {ADDR_W{1'b0}};
                if (start) begin
                    next_state_s = FETCH;
                end else begin
                    next_state_s = IDLE;
                end
            end
            FETCH: begin
                cap_idx_s    = {ADDR_W{1'b0}};
                cap_en_s     = 1'b1;
                next_state_s = SEND;
            end
            SEND: begin
                if (hs_s && out_last_r) begin
                    finish_s     = 1'b1;
                    next_state_s = IDLE;
                end else if (hs_s) begin
                    cap_en_s     = 1'b1;
                    next_state_s = SEND;
                end else begin
                    next_state_s = SEND;
                end
            end
            default: begin
                cap_idx_s    = {ADDR_W{1'b0}};
                next_state_s = IDLE;
            end
        endcase
    end

    // Beat source: $0 is hardwired zero, a same-cycle write wins over the stale read.
    always_comb begin
        cap_data_s = rd_data;
        if (cap_idx_s == {ADDR_W{1'b0}}) begin
            cap_data_s = {DATA_W{1'b0}};
        end else if (wr_en && (wr_addr == cap_idx_s)) begin
            cap_data_s = wr_data;
        end else begin
            cap_data_s = rd_data;
        end
    end

    // State and registered outputs; the beat only changes on a capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            busy_r      <= 1'b0;
            out_valid_r <= 1'b0;
            out_idx_r   <= {ADDR_W{1'b0}};
            out_data_r  <= {DATA_W{1'b0}};
            out_last_r  <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= next_state_s;
            busy_r      <= (next_state_s != IDLE);
            out_valid_r <= (next_state_s == SEND);
            done_r      <= finish_s;
            if (cap_en_s) begin
                out_idx_r  <= cap_idx_s;
                out_data_r <= cap_data_s;
                out_last_r <= (cap_idx_s == LAST_IDX);
            end
        end
    end

    assign rd_addr   = cap_idx_s;
    assign busy      = busy_r;
    assign out_valid = out_valid_r;
    assign out_idx   = out_idx_r;
    assign out_data  = out_data_r;
    assign out_last  = out_last_r;
    assign done      = done_r;

endmodule

// File: tb/tb_grf_dump.sv
// Bench for grf_dump: a GRF array model, a transaction-level expectation model,
// a directed vector table, the directed corner sequences and randomized dumps.
module tb_grf_dump;

    localparam int NR = 32;

    logic        clk = 1'b0;
    logic        reset, start, busy, wr_en, out_valid, out_ready, out_last, done;
    logic [4:0]  rd_addr, wr_addr, out_idx;
    logic [31:0] rd_data, wr_data, out_data;
    logic [31:0] grf [0:NR-1];

    grf_dump dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
        .out_data(out_data), .out_last(out_last), .done(done)
    );

    always #5 clk = ~clk;
    assign rd_data = grf[rd_addr];
    always @(posedge clk) if (wr_en) grf[wr_addr] <= wr_data;

    int errors = 0;
    int checks = 0;

    // expectation model: what each output must show after the coming edge
    bit          m_busy, m_fetch, m_valid, m_last, m_done;
    int          m_idx;
    logic [31:0] m_data;

    typedef struct { int idx; logic [31:0] data; bit last; } beat_t;
    beat_t       q[$];
    logic [31:0] exp_beat [0:NR-1];
    int          cyc = 0, done_cnt = 0, done_cyc = -1, last_cyc = -2;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] snap(input int i);
        if (i == 0) return 32'd0;
        if (wr_en && (int'(wr_addr) == i)) return wr_data;
        return grf[i];
    endfunction

    task automatic step();
        bit nb, nf, nv, nl, nd;
        int ni;
        logic [31:0] nx;
        nb = m_busy; nf = 1'b0; nv = m_valid; nl = m_last; nd = 1'b0; ni = m_idx; nx = m_data;
        if (!reset && out_valid && out_ready) begin
            q.push_back('{int'(out_idx), out_data, out_last});
            if (out_last) last_cyc = cyc;
        end
        if (reset) begin
            nb = 1'b0; nv = 1'b0; nl = 1'b0; ni = 0; nx = 32'd0;
        end else if (m_fetch) begin
            nb = 1'b1; nv = 1'b1; ni = 0; nx = 32'd0; nl = (NR == 1);
        end else if (m_valid) begin
            if (out_ready && m_last) begin
                nb = 1'b0; nv = 1'b0; nd = 1'b1;
            end else if (out_ready) begin
                ni = m_idx + 1; nx = snap(ni); nl = (ni == NR - 1);
            end
        end else if (start) begin
            nf = 1'b1; nb = 1'b1;
        end
        @(posedge clk);
        m_busy = nb; m_fetch = nf; m_valid = nv; m_last = nl; m_done = nd; m_idx = ni; m_data = nx;
        @(negedge clk);
        check("busy", busy, m_busy);
        check("out_valid", out_valid, m_valid);
        check("done", done, m_done);
        if (m_valid) begin
            check("out_idx", out_idx, m_idx);
            check("out_data", out_data, m_data);
            check("out_last", out_last, m_last);
            check("rd_addr_send", rd_addr, (m_idx + 1) % NR);
        end
        if (m_fetch) check("rd_addr_fetch", rd_addr, 32'd0);
        if (done) begin done_cnt++; done_cyc = cyc; end
        cyc++;
    endtask

    task automatic quiet();
        reset = 1'b0; start = 1'b0; wr_en = 1'b0; wr_addr = 5'd0; wr_data = 32'd0;
    endtask

    task automatic preload();
        for (int i = 0; i < NR; i++) begin
            grf[i] = 32'h1000_0000 + i;
            exp_beat[i] = (i == 0) ? 32'd0 : 32'h1000_0000 + i;
        end
    endtask

    task automatic clear_obs();
        q.delete(); done_cnt = 0; done_cyc = -1; last_cyc = -2;
    endtask

    task automatic check_dump();
        check("beat_count", q.size(), NR);
        for (int i = 0; i < q.size() && i < NR; i++) begin
            check("dump_idx", q[i].idx, i);
            check("dump_data", q[i].data, exp_beat[i]);
            check("dump_last", q[i].last, (i == NR - 1));
        end
        check("done_count", done_cnt, 1);
        check("done_after_last", done_cyc, last_cyc);
    endtask

    typedef struct {
        bit rst, st, rdy, we; logic [4:0] wa; logic [31:0] wd;
        bit e_busy, e_valid; logic [4:0] e_idx; logic [31:0] e_data; bit e_last, e_done;
    } vec_t;
    vec_t tbl[$];

    initial begin
        quiet(); reset = 1'b1; out_ready = 1'b0;
        m_busy = 0; m_fetch = 0; m_valid = 0; m_last = 0; m_done = 0; m_idx = 0; m_data = 0;
        preload();
        @(negedge clk);

        // directed vector table
        tbl.push_back('{1,0,0,0,5'd0,32'd0,          0,0,5'd0,32'd0,          0,0});
        tbl.push_back('{0,1,0,0,5'd0,32'd0,          1,0,5'd0,32'd0,          0,0});
        tbl.push_back('{0,0,0,0,5'd0,32'd0,          1,1,5'd0,32'd0,          0,0});
        tbl.push_back('{0,0,1,0,5'd0,32'd0,          1,1,5'd1,32'h1000_0001,  0,0});
        tbl.push_back('{0,0,0,1,5'd2,32'hAAAA_0002,  1,1,5'd1,32'h1000_0001,  0,0});
        tbl.push_back('{0,0,1,0,5'd0,32'd0,          1,1,5'd2,32'hAAAA_0002,  0,0});
        tbl.push_back('{1,0,0,0,5'd0,32'd0,          0,0,5'd0,32'd0,          0,0});
        foreach (tbl[k]) begin
            reset = tbl[k].rst; start = tbl[k].st; out_ready = tbl[k].rdy;
            wr_en = tbl[k].we; wr_addr = tbl[k].wa; wr_data = tbl[k].wd;
            step();
            check("tbl_busy", busy, tbl[k].e_busy);
            check("tbl_valid", out_valid, tbl[k].e_valid);
            check("tbl_done", done, tbl[k].e_done);
            if (tbl[k].e_valid || tbl[k].rst) begin
                check("tbl_idx", out_idx, tbl[k].e_idx);
                check("tbl_data", out_data, tbl[k].e_data);
                check("tbl_last", out_last, tbl[k].e_last);
            end
            if (tbl[k].rst) check("tbl_rd_addr", rd_addr, 32'd0);
        end

        // full dump with ready held high, then restart in the done cycle
        quiet(); preload(); clear_obs();
        start = 1'b1; step(); start = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 40 && !m_done; c++) step();
        check_dump();
        start = 1'b1; step(); start = 1'b0;
        check("restart_on_done", busy, 32'd1);
        for (int c = 0; c < 40; c++) step();

        // ready toggling every cycle
        quiet(); preload(); clear_obs();
        start = 1'b1; step(); start = 1'b0;
        for (int c = 0; c < 90 && !m_done; c++) begin out_ready = cyc[0]; step(); end
        check_dump();

        // snoop bypass on $5 and snapshot of $6 while stalled
        quiet(); preload(); clear_obs(); out_ready = 1'b1;
        start = 1'b1; step(); start = 1'b0;
        for (int c = 0, s6 = 0; c < 60 && !m_done; c++) begin
            wr_en = 1'b0; out_ready = 1'b1;
            if (m_valid && m_idx == 4) begin wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEAD_BEEF; end
            if (m_valid && m_idx == 6 && s6 < 2) begin
                out_ready = 1'b0; s6++;
                if (s6 == 1) begin wr_en = 1'b1; wr_addr = 5'd6; wr_data = 32'hCAFE_F00D; end
            end
            step();
        end
        wr_en = 1'b0;
        exp_beat[5] = 32'hDEAD_BEEF;
        check_dump();

        // $0 written and snooped during beat-0 capture still reads zero
        quiet(); preload(); clear_obs(); out_ready = 1'b1;
        start = 1'b1; wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFF_FFFF; step();
        start = 1'b0; step(); wr_en = 1'b0;
        for (int c = 0; c < 40 && !m_done; c++) step();
        check_dump();

        // start ignored mid-dump, reset mid-dump, then a clean dump
        quiet(); preload(); clear_obs(); out_ready = 1'b1;
        start = 1'b1; step(); start = 1'b0;
        for (int c = 0; c < 30 && !(m_valid && m_idx == 10); c++) begin
            start = (m_valid && m_idx == 3); step();
        end
        start = 1'b0;
        check("pre_reset_beats", q.size(), 10);
        for (int i = 0; i < q.size(); i++) check("pre_reset_idx", q[i].idx, i);
        reset = 1'b1; out_ready = 1'b0; step(); reset = 1'b0;
        check("reset_valid", out_valid, 32'd0);
        check("reset_busy", busy, 32'd0);
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) step();
        check("no_done_after_reset", done_cnt, 32'd0);
        clear_obs();
        start = 1'b1; step(); start = 1'b0;
        for (int c = 0; c < 40 && !m_done; c++) step();
        check_dump();

        // randomized traffic against the model
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < NR; i++) grf[i] = $urandom;
            for (int c = 0; c < 400; c++) begin
                reset     = ($urandom_range(0, 99) == 0);
                start     = ($urandom_range(0, 9) == 0);
                out_ready = ($urandom_range(0, 3) != 0);
                wr_en     = $urandom_range(0, 1);
                wr_addr   = 5'($urandom_range(0, NR - 1));
                wr_data   = $urandom;
                step();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/grf_dump.md
# grf_dump

Sequential read-out engine for the general register file. On a start pulse it walks all 32 GPRs through a GRF read port and streams each value, tagged with its index, over a valid/ready interface to a debug/trace consumer. It snoops the GRF write port so every beat reports the register's content as of the cycle it was sampled. It is the reader counterpart of the CPU's write-back path into the GRF.

## Interface
Parameters:
- NUM_REGS, 32, registers walked (index 0..NUM_REGS-1)
- ADDR_W, 5, register index width
- DATA_W, 32, register data width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle request to begin a dump; ignored while busy
- busy  out  1  high from the cycle after an accepted start until the cycle done is asserted
- rd_addr  out  ADDR_W  address driven to a GRF combinational read port
- rd_data  in  DATA_W  GRF read data for rd_addr, same cycle
- wr_en  in  1  GRF write enable (snoop)
- wr_addr  in  ADDR_W  GRF write address (snoop)
- wr_data  in  DATA_W  GRF write data (snoop)
- out_valid  out  1  beat valid
- out_ready  in  1  consumer accepts the beat
- out_idx  out  ADDR_W  register index of the beat
- out_data  out  DATA_W  register value of the beat
- out_last  out  1  high with the beat for index NUM_REGS-1
- done  out  1  one-cycle pulse after the last beat is accepted

## Operation
- States: IDLE, FETCH, SEND.
- IDLE: busy=0, out_valid=0. start=1 -> FETCH.
- FETCH (one cycle): rd_addr=0; capture beat 0 -> SEND.
- SEND: out_valid=1. rd_addr = out_idx+1 (wraps mod 2^ADDR_W; value irrelevant when out_last=1).
  - Handshake (out_valid && out_ready) with out_last=0: capture next beat (idx+1); stay in SEND.
  - Handshake with out_last=1: -> IDLE; done=1 on the following cycle.
  - No handshake: out_idx/out_data/out_last held stable.
- Capture value for index i: 0 if i==0 (hardwired $0, regardless of rd_data or snoop); else wr_data if wr_en && wr_addr==i in the capture cycle; else rd_data.
- Writes to register i after its capture cycle do not alter the pending beat (snapshot semantics).
- start during busy: ignored, no restart, no queueing.
- reset (any state, incl. mid-dump): -> IDLE at next edge; pending beat dropped, no done.

## Timing
- Reset values: busy=0, out_valid=0, out_idx=0, out_data=0, out_last=0, done=0, rd_addr=0.
- start sampled high at edge T -> FETCH in cycle T+1 -> beat 0 valid in cycle T+2.
- Throughput: one beat/cycle with out_ready held high; 32 beats occupy cycles T+2..T+33; done high in cycle T+34; busy low from cycle T+34.
- All outputs registered except rd_addr (combinational from state/out_idx).
- A new start is accepted in the cycle done is high (state is IDLE).

## Structure
- Shared package grf_pkg: NUM_REGS, REG_ADDR_W, REG_DATA_W constants; dump state enum (IDLE, FETCH, SEND). Reused by GRF and future forwarding logic.
- Single module; no sub-module. Snoop bypass and $0 force are an inline mux feeding the beat register.

## Test plan
- Preload $i=0x1000_0000+i, start, out_ready=1 -> 32 consecutive beats idx 0..31, data[0]=0, data[i]=0x1000_0000+i, out_last only on idx 31, done one cycle after beat 31.
- Same preload, out_ready toggling 1/0 each cycle -> no dropped/duplicated beats; idx/data stable across every stalled cycle; done after the 32nd handshake.
- Write $5<=0xDEADBEEF in the cycle rd_addr==5 -> beat 5 = 0xDEADBEEF; write $6<=0xCAFEF00D one cycle after beat 6 is captured while stalled -> beat 6 keeps 0x1000_0006.
- Write $0<=0xFFFF_FFFF, also snooped during beat-0 capture -> beat 0 data = 0.
- Pulse start again at beat 3 -> ignored, sequence unchanged; reset asserted while beat 10 is valid -> out_valid=0, busy=0 next cycle, no done; next start dumps from idx 0.
